// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one word read per pc over req/ready + rvalid and holds the word for decode.
// Optional FETCH_PERF_EN builds the delivered-instruction and wait-cycle counters.
module instr_fetch_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            pc_step,
  output logic            fetch_err,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] req_pc;
  logic [7:0]      wait_cnt;
  logic [7:0]      cnt_inc;
  logic            drop;
  logic            inst_valid_q;
  logic            accept;
  logic            capture;
  logic            discard;
  logic            timeout;

  assign cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A response arriving with a redirect or a pending drop belongs to a stale pc.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    discard    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop || redirect) begin
            discard    = 1'b1;
            state_next = REQ;
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end else if (cnt_inc == 8'(TIMEOUT_CYC)) begin
          timeout    = 1'b1;
          state_next = REQ;
        end
      end
      HOLD: begin
        if (redirect || inst_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_addr  = imem_req ? {pc[XLEN-1:2], 2'b00} : '0;
  assign inst_valid = inst_valid_q & ~redirect;
  assign pc_step    = inst_valid & inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc       <= '0;
      wait_cnt     <= '0;
      drop         <= 1'b0;
      inst_valid_q <= 1'b0;
      inst         <= '0;
      inst_pc      <= '0;
      fetch_err    <= 1'b0;
    end else begin
      if (accept) begin
        req_pc   <= pc;
        wait_cnt <= '0;
        if (pc[1:0] != 2'b00) fetch_err <= 1'b1;
      end else if (state == WAIT) begin
        wait_cnt <= cnt_inc;
      end
      if (capture) begin
        inst         <= imem_rdata;
        inst_pc      <= req_pc;
        inst_valid_q <= 1'b1;
      end else if (state == HOLD && state_next == REQ) begin
        inst_valid_q <= 1'b0;
      end
      // The retry after a timeout must skip the late response still owed by memory.
      if (discard)                                     drop <= 1'b0;
      else if (timeout || (state == WAIT && redirect)) drop <= 1'b1;
      if (timeout) fetch_err <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pc_step)       perf_fetched <= perf_fetched + 32'd1;
      if (state == WAIT) perf_stall   <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the main flow,
// plus hand-written sequences for misalignment, async reset, timeout/retry and perf counters.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        pc_step;
  logic        fetch_err;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        redirect;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        inst_ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;
    logic        exp_step;
  } vec_t;

  vec_t vecs[23];

  instr_fetch_unit #(.XLEN(32), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .pc_step     (pc_step),
    .fetch_err   (fetch_err),
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] p, input logic rd, input logic rdy,
                              input logic rv, input logic [31:0] dat, input logic ir,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] ins, input logic [31:0] ipc, input logic stp);
    vec_t v;
    v.pc = p; v.redirect = rd; v.ready = rdy; v.rvalid = rv; v.rdata = dat; v.inst_ready = ir;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.exp_inst = ins;
    v.exp_inst_pc = ipc; v.exp_step = stp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    pc          = v.pc;
    redirect    = v.redirect;
    imem_ready  = v.ready;
    imem_rvalid = v.rvalid;
    imem_rdata  = v.rdata;
    inst_ready  = v.inst_ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch with a response in the second WAIT cycle, consumed immediately.
  task automatic fetch2(input logic [31:0] p, input logic [31:0] data);
    pc = p; imem_ready = 1'b1; #1;
    checkOutput("fetch2_req", 32'(imem_req), 32'd1);
    tick();
    imem_ready = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = data;
    tick();
    imem_rvalid = 1'b0; inst_ready = 1'b1; #1;
    checkOutput("fetch2_inst", inst, data);
    checkOutput("fetch2_step", 32'(pc_step), 32'd1);
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(32'h100, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[1]  = mk(32'h100, 0, 1, 0, 32'h0,        0, 1, 32'h100, 0, 32'h0,        32'h0,   0);
    vecs[2]  = mk(32'h100, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[3]  = mk(32'h100, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    for (int i = 4; i <= 8; i++)
      vecs[i] = mk(32'h100, 0, 0, 0, 32'h0,       0, 0, 32'h0,   1, 32'hDEADBEEF, 32'h100, 0);
    vecs[9]  = mk(32'h100, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 32'hDEADBEEF, 32'h100, 1);
    vecs[10] = mk(32'h104, 0, 0, 0, 32'h0,        0, 1, 32'h104, 0, 32'h0,        32'h0,   0);
    vecs[11] = mk(32'h104, 0, 1, 0, 32'h0,        0, 1, 32'h104, 0, 32'h0,        32'h0,   0);
    vecs[12] = mk(32'h104, 0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[13] = mk(32'h200, 1, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[14] = mk(32'h200, 0, 1, 0, 32'h0,        0, 1, 32'h200, 0, 32'h0,        32'h0,   0);
    vecs[15] = mk(32'h300, 1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[16] = mk(32'h300, 0, 0, 1, 32'hBAD,      0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[17] = mk(32'h300, 0, 1, 0, 32'h0,        0, 1, 32'h300, 0, 32'h0,        32'h0,   0);
    vecs[18] = mk(32'h300, 0, 0, 1, 32'h11111111, 0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[19] = mk(32'h300, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 32'h11111111, 32'h300, 1);
    vecs[20] = mk(32'h304, 0, 1, 0, 32'h0,        0, 1, 32'h304, 0, 32'h0,        32'h0,   0);
    vecs[21] = mk(32'h400, 1, 0, 1, 32'h22222222, 0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
    vecs[22] = mk(32'h400, 0, 0, 0, 32'h0,        0, 1, 32'h400, 0, 32'h0,        32'h0,   0);

    rst = 1'b1; pc = 32'h100; redirect = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    #2;
    checkOutput("rst_req",   32'(imem_req),   32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst",  inst,            32'd0);
    checkOutput("rst_err",   32'(fetch_err),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_req", i),   32'(imem_req),   32'(vecs[i].exp_req));
      checkOutput($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_step", i),  32'(pc_step),    32'(vecs[i].exp_step));
      checkOutput($sformatf("v%0d_err", i),   32'(fetch_err),  32'd0);
      if (vecs[i].exp_req)
        checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d_inst", i),    inst,    vecs[i].exp_inst);
        checkOutput($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_inst_pc);
      end
      tick();
    end
    redirect = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; imem_ready = 1'b0;

    // Misaligned pc: aligned address fetched, error flagged on accept.
    pc = 32'h102; #1;
    checkOutput("mis_addr", imem_addr, 32'h100);
    checkOutput("mis_err_before", 32'(fetch_err), 32'd0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; #1;
    checkOutput("mis_err_after", 32'(fetch_err), 32'd1);

    // Async reset in the middle of WAIT.
    #2 rst = 1'b1; #1;
    checkOutput("arst_req",     32'(imem_req),   32'd0);
    checkOutput("arst_valid",   32'(inst_valid), 32'd0);
    checkOutput("arst_inst",    inst,            32'd0);
    checkOutput("arst_inst_pc", inst_pc,         32'd0);
    checkOutput("arst_err",     32'(fetch_err),  32'd0);
    checkOutput("arst_step",    32'(pc_step),    32'd0);
    checkOutput("arst_perf_f",  perf_fetched,    32'd0);
    checkOutput("arst_perf_s",  perf_stall,      32'd0);
    tick();
    rst = 1'b0; pc = 32'h500; #1;
    checkOutput("idle_req", 32'(imem_req), 32'd0);
    tick();
    checkOutput("req_after_idle", 32'(imem_req), 32'd1);
    checkOutput("req_after_idle_addr", imem_addr, 32'h500);

    // Timeout after 16 WAIT cycles, retry, late response dropped.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    repeat (15) tick();
    checkOutput("to_w16_req", 32'(imem_req),  32'd0);
    checkOutput("to_w16_err", 32'(fetch_err), 32'd0);
    tick();
    checkOutput("to_retry_req",  32'(imem_req),  32'd1);
    checkOutput("to_retry_err",  32'(fetch_err), 32'd1);
    checkOutput("to_retry_addr", imem_addr,      32'h500);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0000;
    tick();
    imem_rvalid = 1'b0; #1;
    checkOutput("late_drop_valid", 32'(inst_valid), 32'd0);
    checkOutput("late_drop_req",   32'(imem_req),   32'd1);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
    tick();
    imem_rvalid = 1'b0; inst_ready = 1'b1; #1;
    checkOutput("retry_valid",   32'(inst_valid), 32'd1);
    checkOutput("retry_inst",    inst,            32'hCAFEF00D);
    checkOutput("retry_inst_pc", inst_pc,         32'h500);
    checkOutput("retry_step",    32'(pc_step),    32'd1);
    tick();
    inst_ready = 1'b0;

    // Performance counters over three 2-cycle-latency fetches.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fetch2(32'h600, 32'hA0000001);
    fetch2(32'h604, 32'hA0000002);
    fetch2(32'h608, 32'hA0000003);
    #1;
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", perf_fetched, 32'd3);
    checkOutput("perf_stall",   perf_stall,   32'd6);
`else
    checkOutput("perf_fetched", perf_fetched, 32'd0);
    checkOutput("perf_stall",   perf_stall,   32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
